// File: rtl/motion_qualifier.sv
// PIR motion qualifier: synchroniser, debounce, dropout hold and optional post-release blanking.
// Blanking is compiled in when MOTION_QUAL_BLANK_EN is defined.
module motion_qualifier #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 1000,
   parameter int unsigned BLANK_CYCLES    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sensor_raw_i,
   input  logic        enable_i,
   output logic        motion_o,
   output logic        motion_rise_o,
   output logic [15:0] event_count_o
);

   localparam int unsigned MaxDh  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int unsigned MaxCnt = (MaxDh > BLANK_CYCLES) ? MaxDh : BLANK_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] DebCnt  = CntW'(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] HoldCnt = CntW'(HOLD_CYCLES);
   localparam logic [CntW-1:0] OneCnt  = CntW'(1);
`ifdef MOTION_QUAL_BLANK_EN
   localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StQualify,
      StActive,
`ifdef MOTION_QUAL_BLANK_EN
      StHold,
      StBlank
`else
      StHold
`endif
   } state_e;

`ifdef MOTION_QUAL_BLANK_EN
   localparam state_e RelState = StBlank;
`else
   localparam state_e RelState = StIdle;
`endif

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic [CntW-1:0]        cnt_inc;
   logic                   motion_q;
   logic                   rise_q;
   logic [15:0]            event_q;
   logic [15:0]            event_inc;

   // Plain flop chain; s is sensor_raw_i delayed SYNC_STAGES edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw_i};
      end
   end

   assign s         = sync_q[SYNC_STAGES-1];
   assign cnt_inc   = cnt_q + OneCnt;
   assign event_inc = (event_q == 16'hFFFF) ? event_q : event_q + 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         motion_q <= 1'b0;
         rise_q   <= 1'b0;
         event_q  <= '0;
      end else begin
         rise_q <= 1'b0;
         if (!enable_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            motion_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (s) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        state_q  <= StActive;
                        cnt_q    <= '0;
                        motion_q <= 1'b1;
                        rise_q   <= 1'b1;
                        event_q  <= event_inc;
                     end else begin
                        state_q <= StQualify;
                        cnt_q   <= OneCnt;
                     end
                  end
               end
               StQualify: begin
                  if (!s) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                  end else if (cnt_inc == DebCnt) begin
                     state_q  <= StActive;
                     cnt_q    <= '0;
                     motion_q <= 1'b1;
                     rise_q   <= 1'b1;
                     event_q  <= event_inc;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               StActive: begin
                  if (!s) begin
                     if (HOLD_CYCLES == 1) begin
                        state_q  <= RelState;
                        cnt_q    <= '0;
                        motion_q <= 1'b0;
                     end else begin
                        state_q <= StHold;
                        cnt_q   <= OneCnt;
                     end
                  end
               end
               StHold: begin
                  // A return to high is a retrigger, not a new qualification.
                  if (s) begin
                     state_q <= StActive;
                     cnt_q   <= '0;
                  end else if (cnt_inc == HoldCnt) begin
                     state_q  <= RelState;
                     cnt_q    <= '0;
                     motion_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
`ifdef MOTION_QUAL_BLANK_EN
               StBlank: begin
                  if (cnt_inc == BlankCnt) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
`endif
               default: begin
                  state_q  <= StIdle;
                  cnt_q    <= '0;
                  motion_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign motion_o      = motion_q;
   assign motion_rise_o = rise_q;
   assign event_count_o = event_q;

   a_rise_single : assert property (@(posedge clk) disable iff (reset)
      motion_rise_o |=> !motion_rise_o);
   a_rise_motion : assert property (@(posedge clk) disable iff (reset)
      motion_rise_o |-> motion_o);

endmodule

// File: tb/tb_motion_qualifier.sv
// Directed bench for motion_qualifier at default parameters.
module tb_motion_qualifier;

   logic        clk;
   logic        reset;
   logic        sensor_raw;
   logic        enable;
   logic        motion;
   logic        motion_rise;
   logic [15:0] event_count;

   int n_tests;
   int n_fail;
   int rise_total;
   int hi_cycles;

`ifdef MOTION_QUAL_BLANK_EN
   localparam int EvB    = 1;
   localparam int MotBlk = 0;
`else
   localparam int EvB    = 2;
   localparam int MotBlk = 1;
`endif

   motion_qualifier dut (
      .clk           (clk),
      .reset         (reset),
      .sensor_raw_i  (sensor_raw),
      .enable_i      (enable),
      .motion_o      (motion),
      .motion_rise_o (motion_rise),
      .event_count_o (event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (motion_rise) rise_total++;
         if (motion) hi_cycles++;
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rise_total = 0;
      hi_cycles  = 0;
      reset      = 1'b1;
      sensor_raw = 1'b0;
      enable     = 1'b1;

      // Reset state
      tick(2);
      check("rst_motion", 32'(motion), 0);
      check("rst_rise", 32'(motion_rise), 0);
      check("rst_count", 32'(event_count), 0);
      reset = 1'b0;
      tick(3);
      check("post_rst_motion", 32'(motion), 0);

      // Clean rise: motion after edge 18
      sensor_raw = 1'b1;
      tick(17);
      check("rise_edge17", 32'(motion), 0);
      tick(1);
      check("rise_edge18", 32'(motion), 1);
      check("rise_pulse", 32'(motion_rise), 1);
      check("rise_count", 32'(event_count), 1);
      tick(1);
      check("rise_pulse_end", 32'(motion_rise), 0);
      check("rise_hold", 32'(motion), 1);

      // Dropout of 500, then the 999-clock boundary
      sensor_raw = 1'b0;
      tick(500);
      check("drop500_motion", 32'(motion), 1);
      sensor_raw = 1'b1;
      tick(5);
      sensor_raw = 1'b0;
      tick(999);
      check("drop999_motion", 32'(motion), 1);
      sensor_raw = 1'b1;
      tick(5);
      check("retrig_motion", 32'(motion), 1);
      check("retrig_count", 32'(event_count), 1);
      check("retrig_rises", 32'(rise_total), 1);

      // Release after edge 1002, then a 40-clock pulse 10 clocks later
      sensor_raw = 1'b0;
      tick(1001);
      check("rel_edge1001", 32'(motion), 1);
      tick(1);
      check("rel_edge1002", 32'(motion), 0);
      check("rel_rise", 32'(motion_rise), 0);
      tick(10);
      sensor_raw = 1'b1;
      tick(17);
      check("blank_edge17", 32'(motion), 0);
      tick(1);
      check("blank_edge18", 32'(motion), 32'(MotBlk));
      tick(22);
      sensor_raw = 1'b0;
      check("blank_count", 32'(event_count), 32'(EvB));
      check("blank_rises", 32'(rise_total), 32'(EvB));
      tick(1010);
      check("blank_settle", 32'(motion), 0);

      // Glitch of 15 rejected, 16 accepted
      hi_cycles  = 0;
      sensor_raw = 1'b1;
      tick(15);
      sensor_raw = 1'b0;
      tick(30);
      check("glitch_hi", 32'(hi_cycles), 0);
      check("glitch_count", 32'(event_count), 32'(EvB));
      sensor_raw = 1'b1;
      tick(16);
      sensor_raw = 1'b0;
      tick(1);
      check("p16_edge17", 32'(motion), 0);
      tick(1);
      check("p16_edge18", 32'(motion), 1);
      check("p16_count", 32'(event_count), 32'(EvB + 1));
      tick(1090);
      check("p16_release", 32'(motion), 0);

      // Enable dropped in HOLD
      sensor_raw = 1'b1;
      tick(20);
      check("en_active", 32'(motion), 1);
      check("en_count0", 32'(event_count), 32'(EvB + 2));
      sensor_raw = 1'b0;
      tick(10);
      enable = 1'b0;
      tick(1);
      check("en_hold_motion", 32'(motion), 0);
      check("en_hold_count", 32'(event_count), 32'(EvB + 2));
      enable = 1'b1;
      tick(5);
      check("en_back_motion", 32'(motion), 0);

      // Enable falls on the qualifying edge: enable wins
      sensor_raw = 1'b1;
      tick(17);
      enable = 1'b0;
      tick(1);
      check("en_q_motion", 32'(motion), 0);
      check("en_q_rise", 32'(motion_rise), 0);
      check("en_q_count", 32'(event_count), 32'(EvB + 2));
      enable = 1'b1;
      tick(15);
      check("requal_edge15", 32'(motion), 0);
      tick(1);
      check("requal_edge16", 32'(motion), 1);
      check("requal_rise", 32'(motion_rise), 1);
      check("requal_count", 32'(event_count), 32'(EvB + 3));
      enable     = 1'b0;
      sensor_raw = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(5);

      // Asynchronous reset during QUALIFY
      sensor_raw = 1'b1;
      tick(10);
      reset = 1'b1;
      #1;
      check("arst_motion", 32'(motion), 0);
      check("arst_rise", 32'(motion_rise), 0);
      check("arst_count", 32'(event_count), 0);
      tick(2);
      reset = 1'b0;
      tick(10);
      check("arst_no_pulse", 32'(rise_total), 32'(EvB + 3));
      check("arst_motion_after", 32'(motion), 0);
      sensor_raw = 1'b0;
      tick(20);

      // Saturation
      force dut.event_q = 16'hFFFE;
      tick(1);
      release dut.event_q;
      tick(1);
      check("sat_preload", 32'(event_count), 32'hFFFE);
      sensor_raw = 1'b1;
      tick(17);
      check("sat_edge17", 32'(event_count), 32'hFFFE);
      tick(1);
      check("sat_reach", 32'(event_count), 32'hFFFF);
      check("sat_rise1", 32'(motion_rise), 1);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(16);
      check("sat_stay", 32'(event_count), 32'hFFFF);
      check("sat_rise2", 32'(motion_rise), 1);
      check("sat_motion", 32'(motion), 1);
      tick(1);
      check("sat_rise_end", 32'(motion_rise), 0);
      enable     = 1'b0;
      sensor_raw = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
